// File: rtl/reset_pkg.sv
// Shared types for the reset request combiner: FSM states and cause codes.
package reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_HOLDOFF = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // The watchdog wins over a software request arriving in the same cycle.
    function automatic logic [1:0] pick_cause(input logic wdt_req);
        return wdt_req ? CAUSE_WDT : CAUSE_SW;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] sync_r;

    // Shift ones in once rst_n is released; any low on rst_n clears the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_r[STAGES-1];

endmodule

// File: rtl/reset_request_combiner.sv
// Merges board, software and watchdog reset sources into one minimum-width
// active-low reset with a holdoff window and a sticky cause code.
module reset_request_combiner
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 16,
    parameter int HOLDOFF     = 8,
    parameter int WDT_TIMEOUT = 1048576
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sw_rst_req,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    output logic       resetn_out,
    output logic [1:0] rst_cause
);

    localparam int CNT_LIMIT = (MIN_PULSE > HOLDOFF) ? MIN_PULSE : HOLDOFF;
    localparam int CW = $clog2(CNT_LIMIT) + 1;
    localparam int WW = $clog2(WDT_TIMEOUT) + 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(MIN_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_TIMEOUT - 1);
    localparam logic [WW-1:0] WDT_ONE    = WW'(1'b1);

    logic          rst_sync_n_s;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [WW-1:0] wdt_cnt_r, wdt_cnt_s;
    logic          pend_r, pend_s;
    logic [1:0]    pend_cause_r, pend_cause_s;
    logic [1:0]    cause_r, cause_s;
    logic          out_r;
    logic          wdt_req_s;
    logic          req_s;
    logic [1:0]    req_cause_s;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (resetn),
        .rst_sync_n(rst_sync_n_s)
    );

    // Watchdog only counts in RUN while enabled; a kick in the timeout cycle suppresses the request.
    always_comb begin
        wdt_cnt_s = wdt_cnt_r;
        wdt_req_s = 1'b0;
        if (!wdt_enable || wdt_kick || (state_r != ST_RUN)) begin
            wdt_cnt_s = '0;
        end else begin
            wdt_cnt_s = wdt_cnt_r + WDT_ONE;
            wdt_req_s = (wdt_cnt_r == WDT_LAST);
        end
        req_s       = sw_rst_req | wdt_req_s;
        req_cause_s = pick_cause(wdt_req_s);
    end

    // Next-state logic for the pulse / holdoff / run sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        pend_s       = pend_r;
        pend_cause_s = pend_cause_r;
        cause_s      = cause_r;
        case (state_r)
            ST_ASSERT: begin
                if (req_s) begin
                    cnt_s   = '0;
                    cause_s = req_cause_s;
                end else if (cnt_r == PULSE_LAST) begin
                    cnt_s   = '0;
                    state_s = (HOLDOFF == 0) ? ST_RUN : ST_HOLDOFF;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (req_s) begin
                    pend_s       = 1'b1;
                    pend_cause_s = req_cause_s;
                end else begin
                    pend_s       = pend_r;
                    pend_cause_s = pend_cause_r;
                end
                // A request landing in the last holdoff cycle is honoured like a pending one.
                if (cnt_r == HOLD_LAST) begin
                    cnt_s = '0;
                    if (pend_r || req_s) begin
                        state_s = ST_ASSERT;
                        pend_s  = 1'b0;
                        cause_s = req_s ? req_cause_s : pend_cause_r;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    state_s = ST_ASSERT;
                    cnt_s   = '0;
                    cause_s = req_cause_s;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_ASSERT;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counters and cause; everything clears on the synchronized board reset.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            state_r      <= ST_ASSERT;
            cnt_r        <= '0;
            wdt_cnt_r    <= '0;
            pend_r       <= 1'b0;
            pend_cause_r <= CAUSE_POR;
            cause_r      <= CAUSE_POR;
            out_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            wdt_cnt_r    <= wdt_cnt_s;
            pend_r       <= pend_s;
            pend_cause_r <= pend_cause_s;
            cause_r      <= cause_s;
            out_r        <= (state_s != ST_ASSERT);
        end
    end

    assign resetn_out = out_r & rst_sync_n_s;
    assign rst_cause  = cause_r;

endmodule

// File: tb/tb_reset_request_combiner.sv
// Self-checking bench for reset_request_combiner: cycle vectors plus board-reset sequences.
module tb_reset_request_combiner;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       resetn_out;
    logic [1:0] rst_cause;

    typedef struct {
        logic       sw;
        logic       en;
        logic       kick;
        logic       out;
        logic [1:0] cause;
        int         seg;
    } vec_t;

    typedef struct {
        logic       out;
        logic [1:0] cause;
        int         seg;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reset_request_combiner #(
        .SYNC_STAGES(2),
        .MIN_PULSE  (4),
        .HOLDOFF    (3),
        .WDT_TIMEOUT(10)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sw_rst_req(sw_rst_req),
        .wdt_enable(wdt_enable),
        .wdt_kick  (wdt_kick),
        .resetn_out(resetn_out),
        .rst_cause (rst_cause)
    );

    task automatic add(input int n, input logic sw, input logic en, input logic kick,
                       input logic out, input logic [1:0] cause, input int seg);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.sw = sw; v.en = en; v.kick = kick; v.out = out; v.cause = cause; v.seg = seg;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic exp_out, input logic [1:0] exp_cause);
        checks++;
        if (resetn_out !== exp_out || rst_cause !== exp_cause) begin
            failures++;
            $display("FAIL %s: got resetn_out=%0b rst_cause=%b, expected resetn_out=%0b rst_cause=%b",
                     name, resetn_out, rst_cause, exp_out, exp_cause);
        end
    endtask

    // Board reset release: resetn_out must rise exactly at edge E0+SYNC_STAGES-1+MIN_PULSE.
    task automatic por_release(input string tag);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_e%0d", tag, k), (k == 5), 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // seg1: finish power-on holdoff, idle in RUN
        add(5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1);
        // seg2: one-cycle software request -> 4 low cycles, then holdoff, RUN
        add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2);
        add(3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2);
        add(6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2);
        // seg3: request during holdoff cycle 1 -> second pulse right after holdoff
        add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3);
        add(3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3);
        add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3);
        add(1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3);
        add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3);
        add(4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3);
        add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3);
        add(3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3);
        // seg4: watchdog enabled from RUN entry, no kick -> falls on the 10th edge
        add(9, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4);
        add(4, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4);
        add(4, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4);
        // seg5: kick every 9 cycles keeps the system out of reset for 200 cycles
        for (int i = 0; i < 200; i++) begin
            add(1, 1'b0, 1'b1, ((i % 9) == 8), 1'b1, 2'b10, 5);
        end
        // seg6: kick in the exact timeout cycle suppresses the watchdog
        add(7, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 6);
        add(1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 6);
        // seg7: software reset to set cause 01 before the simultaneous test
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 7);
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 7);
        add(4, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 7);
        // seg8: software request in the watchdog timeout cycle -> single pulse, cause 10
        add(9, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 8);
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8);
        add(3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8);
        add(4, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 8);
        add(5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8);

        // Power-on: resetn held low 5 cycles, then released
        repeat (5) @(posedge clk);
        #1;
        check("por_hold", 1'b0, 2'b00);
        por_release("por_rise");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            sw_rst_req = vecs[i].sw;
            wdt_enable = vecs[i].en;
            wdt_kick   = vecs[i].kick;
            exp_q.push_back('{vecs[i].out, vecs[i].cause, vecs[i].seg});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("seg%0d_row%0d", e.seg, i), e.out, e.cause);
        end

        // Board reset during ASSERT cycle 2 aborts the pulse and clears the cause
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check("bor_assert_c1", 1'b0, 2'b01);
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(posedge clk);
        #1;
        check("bor_assert_c2", 1'b0, 2'b01);
        #2;
        resetn = 1'b0;
        #1;
        check("bor_async_clear", 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        por_release("bor_rise");
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bor_no_extra_%0d", k), 1'b1, 2'b00);
        end

        // Board reset in RUN drops resetn_out immediately, between clock edges
        #2;
        resetn = 1'b0;
        #1;
        check("run_async_low", 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
